// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM
// state encoding, response constants and the latched request record.
package dmem_pkg;

  // RISC-V load/store funct3 encodings (width selector plus unsigned flag).
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Response-type values.
  localparam logic        RSP_OK      = 1'b0;
  localparam logic        RSP_ERR     = 1'b1;
  localparam logic [31:0] RSP_NO_DATA = 32'h0000_0000;

  // Request fields captured in the acceptance cycle.
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RISC-V loads and stores: merges store data into
// the old word, produces the byte write mask, extracts and extends load
// data, and flags misaligned or undefined accesses. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [3:0]  byte_mask,
  output logic [31:0] load_val,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [31:0] wrep;

  assign shifted = old_word >> {lane, 3'b000};

  // Decode access width, build the lane mask and the extended load value.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a value
    // unassigned and infer a latch.
    byte_mask = 4'b0000;
    load_val  = 32'h0000_0000;
    wrep      = wdata;
    misalign  = 1'b0;
    illegal   = 1'b0;
    unique case (funct3)
      F3_B: begin
        byte_mask = 4'b0001 << lane;
        wrep      = {4{wdata[7:0]}};
        load_val  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        illegal  = is_write;
        load_val = {24'h0, shifted[7:0]};
      end
      F3_H: begin
        byte_mask = 4'b0011 << {lane[1], 1'b0};
        wrep      = {2{wdata[15:0]}};
        misalign  = lane[0];
        load_val  = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_HU: begin
        illegal  = is_write;
        misalign = lane[0];
        load_val = {16'h0, shifted[15:0]};
      end
      F3_W: begin
        byte_mask = 4'b1111;
        misalign  = (lane != 2'b00);
        load_val  = old_word;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Merge replicated store data into the old word under the byte mask.
  always_comb begin
    store_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_mask[i]) store_word[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port. Accepts one request at a
// time, waits a fixed latency, executes the access on a single edge and
// holds the response until the initiator takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  // NOTE: the storage array carries no reset; contents survive reset and
  // clearing it would only cost a huge reset fan-out for no benefit.
  logic [31:0] mem [DEPTH_WORDS];

  req_t             req_in;
  req_t             op;
  logic             exec_en;
  logic [31:0]      offset;
  logic             below_base;
  logic             above_top;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      old_word;
  logic [31:0]      store_word;
  logic [3:0]       byte_mask;
  logic [31:0]      load_val;
  logic             misalign;
  logic             illegal;
  logic             access_err;

  assign req_in = '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

  // With a single-cycle latency the access runs on the acceptance edge
  // from the live inputs; otherwise it runs from the latched request on
  // the last WAIT edge.
  assign op      = (LATENCY == 1) ? req_in : req_q;
  assign exec_en = (LATENCY == 1) ? (state_q == ST_IDLE && req_valid)
                                  : (state_q == ST_WAIT && cnt_q == 4'd1);

  // Unsigned range check without wrap: below-base addresses never alias.
  assign offset     = op.addr - BASE_ADDR;
  assign below_base = (op.addr < BASE_ADDR);
  assign above_top  = ({1'b0, offset} >= SPAN_BYTES);
  assign word_idx   = offset[IDX_W+1:2];
  assign old_word   = mem[word_idx];
  assign access_err = below_base | above_top | misalign | illegal;

  dmem_lane_align u_lane_align (
    .is_write   (op.write),
    .funct3     (op.funct3),
    .lane       (op.addr[1:0]),
    .old_word   (old_word),
    .wdata      (op.wdata),
    .store_word (store_word),
    .byte_mask  (byte_mask),
    .load_val   (load_val),
    .misalign   (misalign),
    .illegal    (illegal)
  );

  // Next-state, counter, request latch and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = RSP_NO_DATA;
          error_d = RSP_OK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (exec_en) begin
      error_d = access_err ? RSP_ERR : RSP_OK;
      rdata_d = (access_err || op.write) ? RSP_NO_DATA : load_val;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= RSP_NO_DATA;
      error_q <= RSP_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Commit legal stores on the execution edge; errors leave storage intact.
  always_ff @(posedge clk) begin
    if (exec_en && op.write && !access_err) mem[word_idx] <= store_word;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// function and a LATENCY=3 instance for the mid-store reset scenario.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        sel3;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_valid2, req_ready2, rsp_valid2, rsp_error2;
  logic [31:0] rsp_rdata2;
  logic        req_valid3, req_ready3, rsp_valid3, rsp_error3;
  logic [31:0] rsp_rdata3;

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_error;
  logic [31:0] cur_rsp_rdata;

  int total = 0;
  int bad   = 0;

  assign req_valid2    = req_valid & ~sel3;
  assign req_valid3    = req_valid & sel3;
  assign cur_req_ready = sel3 ? req_ready3 : req_ready2;
  assign cur_rsp_valid = sel3 ? rsp_valid3 : rsp_valid2;
  assign cur_rsp_error = sel3 ? rsp_error3 : rsp_error2;
  assign cur_rsp_rdata = sel3 ? rsp_rdata3 : rsp_rdata2;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid2),
    .req_ready  (req_ready2),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid2),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata2),
    .rsp_error  (rsp_error2)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid3),
    .req_ready  (req_ready3),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid3),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata3),
    .rsp_error  (rsp_error3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Issue one request to the selected instance, checking acceptance,
  // latency and post-retirement clearing. Called 1 time unit after a
  // rising edge with the instance idle; returns {rsp_error, rsp_rdata}.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input string name,
                        output logic [32:0] got);
    int n;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    total++;
    if (cur_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s req_ready after accept: got %b want 0", name, cur_req_ready);
    end
    n = 1;
    while (cur_rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
    end
    got = {cur_rsp_error, cur_rsp_rdata};
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if ({cur_req_ready, cur_rsp_valid, cur_rsp_error, cur_rsp_rdata} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL %s retire: got rdy=%b vld=%b err=%b data=%h want 1 0 0 00000000",
               name, cur_req_ready, cur_rsp_valid, cur_rsp_error, cur_rsp_rdata);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({req_ready2, rsp_valid2, rsp_error2, rsp_rdata2} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL reset dut2: got rdy=%b vld=%b err=%b data=%h want 1 0 0 00000000",
               req_ready2, rsp_valid2, rsp_error2, rsp_rdata2);
    end
    total++;
    if ({req_ready3, rsp_valid3, rsp_error3, rsp_rdata3} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL reset dut3: got rdy=%b vld=%b err=%b data=%h want 1 0 0 00000000",
               req_ready3, rsp_valid3, rsp_error3, rsp_rdata3);
    end
  endtask

  task automatic test_word();
    logic [32:0] got;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 2, "sw_10", got);
    total++;
    if (got !== {1'b0, 32'h0}) begin bad++; $display("FAIL sw_10 rsp: got %h want 000000000", got); end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 2, "lw_10", got);
    total++;
    if (got !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL lw_10: got %h want 0deadbeef", got); end
    do_req(1'b1, 3'd2, 32'hFFC, 32'h7654_3210, 2, "sw_top", got);
    do_req(1'b0, 3'd2, 32'hFFC, 32'h0, 2, "lw_top", got);
    total++;
    if (got !== {1'b0, 32'h7654_3210}) begin bad++; $display("FAIL lw_top: got %h want 076543210", got); end
  endtask

  task automatic test_byte();
    logic [32:0] got;
    do_req(1'b1, 3'd2, 32'h20, 32'h0, 2, "sw_20_zero", got);
    do_req(1'b1, 3'd0, 32'h23, 32'h0000_00A5, 2, "sb_23", got);
    total++;
    if (got !== {1'b0, 32'h0}) begin bad++; $display("FAIL sb_23 rsp: got %h want 000000000", got); end
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 2, "lw_20_b", got);
    total++;
    if (got !== {1'b0, 32'hA500_0000}) begin bad++; $display("FAIL lw_20_b: got %h want 0a5000000", got); end
    do_req(1'b0, 3'd0, 32'h23, 32'h0, 2, "lb_23", got);
    total++;
    if (got !== {1'b0, 32'hFFFF_FFA5}) begin bad++; $display("FAIL lb_23: got %h want 0ffffffa5", got); end
    do_req(1'b0, 3'd4, 32'h23, 32'h0, 2, "lbu_23", got);
    total++;
    if (got !== {1'b0, 32'h0000_00A5}) begin bad++; $display("FAIL lbu_23: got %h want 0000000a5", got); end
  endtask

  task automatic test_half();
    logic [32:0] got;
    do_req(1'b1, 3'd2, 32'h20, 32'h1122_3344, 2, "sw_20", got);
    do_req(1'b1, 3'd1, 32'h22, 32'h0000_8001, 2, "sh_22", got);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 2, "lw_20_h", got);
    total++;
    if (got !== {1'b0, 32'h8001_3344}) begin bad++; $display("FAIL lw_20_h: got %h want 080013344", got); end
    do_req(1'b0, 3'd1, 32'h22, 32'h0, 2, "lh_22", got);
    total++;
    if (got !== {1'b0, 32'hFFFF_8001}) begin bad++; $display("FAIL lh_22: got %h want 0ffff8001", got); end
    do_req(1'b0, 3'd5, 32'h22, 32'h0, 2, "lhu_22", got);
    total++;
    if (got !== {1'b0, 32'h0000_8001}) begin bad++; $display("FAIL lhu_22: got %h want 000008001", got); end
    do_req(1'b0, 3'd1, 32'h20, 32'h0, 2, "lh_20", got);
    total++;
    if (got !== {1'b0, 32'h0000_3344}) begin bad++; $display("FAIL lh_20: got %h want 000003344", got); end
    do_req(1'b0, 3'd0, 32'h20, 32'h0, 2, "lb_20", got);
    total++;
    if (got !== {1'b0, 32'h0000_0044}) begin bad++; $display("FAIL lb_20: got %h want 000000044", got); end
  endtask

  task automatic test_errors();
    logic [32:0] got;
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 2, "lw_misalign", got);
    total++;
    if (got !== {1'b1, 32'h0}) begin bad++; $display("FAIL lw_misalign: got %h want 100000000", got); end
    do_req(1'b0, 3'd1, 32'h21, 32'h0, 2, "lh_misalign", got);
    total++;
    if (got !== {1'b1, 32'h0}) begin bad++; $display("FAIL lh_misalign: got %h want 100000000", got); end
    do_req(1'b1, 3'd2, 32'h0, 32'h0BAD_F00D, 2, "sw_0", got);
    do_req(1'b1, 3'd2, 32'h1000, 32'hFFFF_FFFF, 2, "sw_range", got);
    total++;
    if (got !== {1'b1, 32'h0}) begin bad++; $display("FAIL sw_range: got %h want 100000000", got); end
    do_req(1'b0, 3'd2, 32'h0, 32'h0, 2, "lw_0_after", got);
    total++;
    if (got !== {1'b0, 32'h0BAD_F00D}) begin bad++; $display("FAIL lw_0_after: got %h want 00badf00d", got); end
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 2, "load_f3_3", got);
    total++;
    if (got !== {1'b1, 32'h0}) begin bad++; $display("FAIL load_f3_3: got %h want 100000000", got); end
    do_req(1'b1, 3'd4, 32'h10, 32'h0, 2, "store_f3_4", got);
    total++;
    if (got !== {1'b1, 32'h0}) begin bad++; $display("FAIL store_f3_4: got %h want 100000000", got); end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 2, "lw_10_intact", got);
    total++;
    if (got !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL lw_10_intact: got %h want 0deadbeef", got); end
  endtask

  task automatic test_backpressure();
    int n;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    n = 0;
    while (rsp_valid2 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid2, req_ready2, rsp_error2, rsp_rdata2} !== {3'b100, 32'hDEADBEEF}) begin
        bad++;
        $display("FAIL backpressure cycle %0d: got vld=%b rdy=%b err=%b data=%h want 1 0 0 deadbeef",
                 i, rsp_valid2, req_ready2, rsp_error2, rsp_rdata2);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if ({req_ready2, rsp_valid2, rsp_rdata2} !== {2'b10, 32'h0}) begin
      bad++;
      $display("FAIL backpressure release: got rdy=%b vld=%b data=%h want 1 0 00000000",
               req_ready2, rsp_valid2, rsp_rdata2);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] got;
    do_req(1'b1, 3'd2, 32'h40, 32'hA1B2_C3D4, 2, "b2b_sw", got);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, 2, "b2b_lw", got);
    total++;
    if (got !== {1'b0, 32'hA1B2_C3D4}) begin bad++; $display("FAIL b2b_lw: got %h want 0a1b2c3d4", got); end
    do_req(1'b0, 3'd4, 32'h41, 32'h0, 2, "b2b_lbu", got);
    total++;
    if (got !== {1'b0, 32'h0000_00C3}) begin bad++; $display("FAIL b2b_lbu: got %h want 0000000c3", got); end
  endtask

  task automatic test_reset_in_resp();
    logic [32:0] got;
    int n;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    n = 0;
    while (rsp_valid2 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    #1;
    total++;
    if ({req_ready2, rsp_valid2, rsp_error2, rsp_rdata2} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL reset_in_resp: got rdy=%b vld=%b err=%b data=%h want 1 0 0 00000000",
               req_ready2, rsp_valid2, rsp_error2, rsp_rdata2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 2, "lw_after_rst", got);
    total++;
    if (got !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL lw_after_rst: got %h want 0deadbeef", got); end
  endtask

  task automatic test_reset_mid_store();
    logic [32:0] got;
    sel3 = 1'b1;
    do_req(1'b1, 3'd2, 32'h30, 32'hCAFE_F00D, 3, "l3_sw_prior", got);
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h30;
    req_wdata  = 32'h1234_5678;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if ({req_ready3, rsp_valid3, rsp_error3, rsp_rdata3} !== {3'b100, 32'h0}) begin
      bad++;
      $display("FAIL reset_mid_store: got rdy=%b vld=%b err=%b data=%h want 1 0 0 00000000",
               req_ready3, rsp_valid3, rsp_error3, rsp_rdata3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_req(1'b0, 3'd2, 32'h30, 32'h0, 3, "l3_lw_30", got);
    total++;
    if (got !== {1'b0, 32'hCAFE_F00D}) begin bad++; $display("FAIL l3_lw_30: got %h want 0cafef00d", got); end
    sel3 = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    sel3       = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_in_resp();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
